// File: rtl/sap2_pkg.sv
// Shared opcodes, T-state encoding and instruction field helpers
// for the SAP-2 accumulator core.
package sap2_pkg;

    localparam int INSTR_MAXW = 32;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [3:0] {
        TS_HALT = 4'b0000,
        TS_T1   = 4'b0001,
        TS_T2   = 4'b0010,
        TS_T3   = 4'b0100,
        TS_T4   = 4'b1000
    } tstate_e;

    function automatic logic [3:0] sap2_opcode(
        input logic [INSTR_MAXW-1:0] instr,
        input int                    data_w
    );
        return instr[data_w-1 -: 4];
    endfunction

    function automatic logic [INSTR_MAXW-1:0] sap2_operand(
        input logic [INSTR_MAXW-1:0] instr,
        input int                    addr_w
    );
        return instr & ((INSTR_MAXW'(1) << addr_w) - INSTR_MAXW'(1));
    endfunction

endpackage

// File: rtl/sap2_alu.sv
// Combinational add/subtract unit; carry doubles as borrow on subtract.
module sap2_alu
    import sap2_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] w_res;

    // Zero-extended subtract sets the top bit exactly when a < b
    assign w_res = sub ? ({1'b0, a} - {1'b0, b})
                       : ({1'b0, a} + {1'b0, b});
    assign sum   = w_res[DATA_W-1:0];
    assign carry = w_res[DATA_W];
    assign zero  = (w_res[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap2_cpu_core.sv
// SAP-2 accumulator CPU: one-hot T1..T4 sequencer, Z/C flags, jumps.
// Optional SAP2_SINGLE_STEP_EN adds step/waiting single-step control.
module sap2_cpu_core
    import sap2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SAP2_SINGLE_STEP_EN
    input  logic              step,
    output logic              waiting,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [3:0]        t_state,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              flag_z,
    output logic              flag_c
);

    if (ADDR_W > DATA_W - 4) begin : g_bad_widths
        $error("sap2_cpu_core: ADDR_W must be <= DATA_W-4");
    end

    tstate_e           r_t, w_t_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [DATA_W-1:0] r_ir, w_ir_nxt;
    logic [DATA_W-1:0] r_acc, w_acc_nxt;
    logic [DATA_W-1:0] r_out, w_out_nxt;
    logic              r_z, w_z_nxt;
    logic              r_c, w_c_nxt;
    logic              r_ov, w_ov_nxt;
    logic              r_halted, w_halt_nxt;
    logic              w_re, w_we, w_go;
    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_opnd;
    logic [DATA_W-1:0] w_sum;
    logic              w_cy, w_zero, w_sub;

    assign w_op   = sap2_opcode(INSTR_MAXW'(r_ir), DATA_W);
    assign w_opnd = ADDR_W'(sap2_operand(INSTR_MAXW'(r_ir), ADDR_W));
    assign w_sub  = (w_op == OP_SUB);

`ifdef SAP2_SINGLE_STEP_EN
    assign w_go    = step;
    assign waiting = r_t[0] & ~step;
`else
    assign w_go = 1'b1;
`endif

    sap2_alu #(.DATA_W(DATA_W)) u_alu (
        .a     (r_acc),
        .b     (mem_rdata),
        .sub   (w_sub),
        .sum   (w_sum),
        .carry (w_cy),
        .zero  (w_zero)
    );

    always_comb begin
        w_t_nxt    = r_t;
        w_pc_nxt   = r_pc;
        w_ir_nxt   = r_ir;
        w_acc_nxt  = r_acc;
        w_out_nxt  = r_out;
        w_z_nxt    = r_z;
        w_c_nxt    = r_c;
        w_ov_nxt   = 1'b0;
        w_halt_nxt = r_halted;
        w_re       = 1'b0;
        w_we       = 1'b0;
        mem_addr   = r_pc;
        unique case (1'b1)
            r_t[0]: begin
                if (w_go) begin
                    w_re     = 1'b1;
                    w_pc_nxt = r_pc + ADDR_W'(1);
                    w_t_nxt  = TS_T2;
                end
            end
            r_t[1]: begin
                w_ir_nxt = mem_rdata;
                w_t_nxt  = TS_T3;
            end
            r_t[2]: begin
                w_t_nxt = TS_T1;
                case (w_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        mem_addr = w_opnd;
                        w_re     = 1'b1;
                        w_t_nxt  = TS_T4;
                    end
                    OP_STA: begin
                        mem_addr = w_opnd;
                        w_we     = 1'b1;
                    end
                    OP_LDI: begin
                        w_acc_nxt = DATA_W'(w_opnd);
                        w_z_nxt   = (w_opnd == '0);
                    end
                    OP_JMP: w_pc_nxt = w_opnd;
                    OP_JZ:  if (r_z) w_pc_nxt = w_opnd;
                    OP_JC:  if (r_c) w_pc_nxt = w_opnd;
                    OP_OUT: begin
                        w_out_nxt = r_acc;
                        w_ov_nxt  = 1'b1;
                    end
                    OP_HLT: begin
                        w_halt_nxt = 1'b1;
                        w_t_nxt    = TS_HALT;
                    end
                    default: ;
                endcase
            end
            r_t[3]: begin
                w_t_nxt = TS_T1;
                if (w_op == OP_LDA) begin
                    w_acc_nxt = mem_rdata;
                    w_z_nxt   = (mem_rdata == '0);
                end else begin
                    w_acc_nxt = w_sum;
                    w_z_nxt   = w_zero;
                    w_c_nxt   = w_cy;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t      <= TS_T1;
            r_pc     <= '0;
            r_ir     <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_ov     <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_t      <= w_t_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_acc    <= w_acc_nxt;
            r_out    <= w_out_nxt;
            r_z      <= w_z_nxt;
            r_c      <= w_c_nxt;
            r_ov     <= w_ov_nxt;
            r_halted <= w_halt_nxt;
        end
    end

    // Strobes are gated so a reset arriving mid-instruction drops any write
    assign mem_re    = w_re & ~rst;
    assign mem_we    = w_we & ~rst;
    assign mem_wdata = r_acc;
    assign out_data  = r_out;
    assign out_valid = r_ov;
    assign halted    = r_halted;
    assign t_state   = r_t;
    assign pc_out    = r_pc;
    assign acc_out   = r_acc;
    assign flag_z    = r_z;
    assign flag_c    = r_c;

endmodule

// File: tb/tb_sap2_cpu_core.sv
// Directed bench for sap2_cpu_core: default 8/4 core plus a 12/8 core.
module tb_sap2_cpu_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_w = 1'b1;
    logic step = 1'b1;

    logic [3:0] mem_addr;
    logic       mem_re, mem_we;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] out_data, acc_out;
    logic       out_valid, halted, flag_z, flag_c;
    logic [3:0] t_state, pc_out;
    logic       waiting;

    logic [7:0]  w_addr;
    logic        w_re, w_we;
    logic [11:0] w_wdata, w_rdata, w_out, w_acc;
    logic        w_ov, w_halted, w_z, w_c, w_wait;
    logic [3:0]  w_ts;
    logic [7:0]  w_pc;

    logic [7:0]  mem [16];
    logic [11:0] memw [256];

    int n_chk = 0;
    int n_fail = 0;
    int ov_cnt, we_cnt, st_cnt, ncyc;
    logic [7:0] outs [$];

    always #5 clk = ~clk;

    sap2_cpu_core #(.DATA_W(8), .ADDR_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SAP2_SINGLE_STEP_EN
        .step      (step),
        .waiting   (waiting),
`endif
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .t_state   (t_state),
        .pc_out    (pc_out),
        .acc_out   (acc_out),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    sap2_cpu_core #(.DATA_W(12), .ADDR_W(8)) u_wide (
        .clk       (clk),
        .rst       (rst_w),
`ifdef SAP2_SINGLE_STEP_EN
        .step      (step),
        .waiting   (w_wait),
`endif
        .mem_addr  (w_addr),
        .mem_re    (w_re),
        .mem_we    (w_we),
        .mem_wdata (w_wdata),
        .mem_rdata (w_rdata),
        .out_data  (w_out),
        .out_valid (w_ov),
        .halted    (w_halted),
        .t_state   (w_ts),
        .pc_out    (w_pc),
        .acc_out   (w_acc),
        .flag_z    (w_z),
        .flag_c    (w_c)
    );

`ifndef SAP2_SINGLE_STEP_EN
    assign waiting = 1'b0;
    assign w_wait  = 1'b0;
`endif

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (w_re) w_rdata <= memw[w_addr];
        if (w_we) memw[w_addr] = w_wdata;
    end

    always @(negedge clk) begin
        if (out_valid) begin
            ov_cnt++;
            outs.push_back(out_data);
        end
        if (mem_we) we_cnt++;
        if (mem_re || mem_we) st_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ov_cnt = 0;
        we_cnt = 0;
        st_cnt = 0;
        outs.delete();
    endtask

    task automatic run_halt(input int bound, output int n);
        n = 0;
        while (!halted && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        int s0;
        // SAP-1 compatible program
        clear_mem();
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'h1B;
        mem[3] = 8'h2B; mem[4] = 8'hE0; mem[5] = 8'hF0;
        mem[9] = 8'h01; mem[10] = 8'h02; mem[11] = 8'h03;
        do_reset();
        rst = 1'b0;
        run_halt(100, ncyc);
        chk("sap1_cycles", ncyc, 22);
        chk("sap1_out", out_data, 8'h03);
        chk("sap1_ovcnt", ov_cnt, 1);
        chk("sap1_acc", acc_out, 8'h03);
        chk("sap1_pc", pc_out, 4'h6);
        chk("sap1_tstate", t_state, 4'b0000);
        s0 = st_cnt;
        repeat (10) begin @(posedge clk); #1; end
        chk("sap1_nostrobe", st_cnt, s0);
        chk("sap1_frozen_pc", pc_out, 4'h6);

        // Reset state from a dirty machine, then store/load
        clear_mem();
        mem[0] = 8'h45; mem[1] = 8'h3C; mem[2] = 8'h40;
        mem[3] = 8'h0C; mem[4] = 8'hE0; mem[5] = 8'hF0;
        do_reset();
        chk("rst_tstate", t_state, 4'b0001);
        chk("rst_pc", pc_out, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_out", out_data, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_strobes", {mem_re, mem_we}, 0);
        chk("rst_flags", {flag_z, flag_c}, 0);
        rst = 1'b0;
        run_halt(100, ncyc);
        chk("sta_mem", mem[12], 8'h05);
        chk("sta_wecnt", we_cnt, 1);
        chk("sta_out", out_data, 8'h05);
        chk("sta_z", flag_z, 0);

        // Countdown loop
        clear_mem();
        mem[0] = 8'h43; mem[1] = 8'h2F; mem[2] = 8'hE0;
        mem[3] = 8'h65; mem[4] = 8'h51; mem[5] = 8'hF0;
        mem[15] = 8'h01;
        do_reset();
        rst = 1'b0;
        run_halt(200, ncyc);
        chk("cd_count", outs.size(), 3);
        if (outs.size() == 3) begin
            chk("cd_out0", outs[0], 8'h02);
            chk("cd_out1", outs[1], 8'h01);
            chk("cd_out2", outs[2], 8'h00);
        end
        chk("cd_z", flag_z, 1);
        chk("cd_pc", pc_out, 4'h6);

        // Carry, JC and borrow
        clear_mem();
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'h74;
        mem[3] = 8'hF0; mem[4] = 8'h2A; mem[5] = 8'hF0;
        mem[9] = 8'hFF; mem[10] = 8'h01;
        do_reset();
        rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("add_acc", acc_out, 8'h00);
        chk("add_zc", {flag_z, flag_c}, 2'b11);
        run_halt(100, ncyc);
        chk("jc_pc", pc_out, 4'h6);
        chk("sub_acc", acc_out, 8'hFF);
        chk("sub_zc", {flag_z, flag_c}, 2'b01);

        // Reset during STA T3
        clear_mem();
        mem[0] = 8'h45; mem[1] = 8'h3C; mem[2] = 8'hF0;
        mem[12] = 8'hAA;
        do_reset();
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("sta_t3", t_state, 4'b0100);
        chk("sta_we_pre", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rst_we_off", mem_we, 0);
        @(posedge clk); #1;
        chk("rst_mid_pc", pc_out, 0);
        chk("rst_mid_ts", t_state, 4'b0001);
        chk("rst_mid_mem", mem[12], 8'hAA);
        chk("rst_mid_we", we_cnt, 0);

        // Wide core: JMP FF, LDI 7 at FF, pc wraps
        for (int i = 0; i < 256; i++) memw[i] = 12'h000;
        memw[0]   = 12'h5FF;
        memw[255] = 12'h407;
        rst_w = 1'b1;
        @(posedge clk); #1;
        rst_w = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("w_jmp_pc", w_pc, 8'hFF);
        repeat (3) begin @(posedge clk); #1; end
        chk("w_wrap_pc", w_pc, 8'h00);
        chk("w_ldi_acc", w_acc, 12'h007);
        chk("w_ts", w_ts, 4'b0001);
        rst_w = 1'b1;

`ifdef SAP2_SINGLE_STEP_EN
        clear_mem();
        mem[0] = 8'h45; mem[1] = 8'hE0; mem[2] = 8'hF0;
        step = 1'b0;
        do_reset();
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("ss_idle_pc", pc_out, 0);
        chk("ss_idle_wait", waiting, 1);
        chk("ss_idle_strb", st_cnt, 0);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("ss_one_pc", pc_out, 1);
        chk("ss_one_acc", acc_out, 8'h05);
        chk("ss_one_wait", waiting, 1);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("ss_two_pc", pc_out, 2);
        chk("ss_two_out", out_data, 8'h05);
        chk("ss_two_ov", ov_cnt, 1);
        step = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
